operand_entry_ctrl: RTL and testbench

OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

---
 rtl/operand_entry_pkg.sv | 66 ++++++
 rtl/operand_timeout_cnt.sv | 37 +++
 rtl/operand_entry_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_operand_entry_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_entry_pkg.sv
// Shared definitions for the calculator operand-entry controller:
// FSM state encodings, keypad codes, operator encodings and key decode helpers.
package operand_entry_pkg;

  // FSM state encodings (plain constants for compatibility with older code)
  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_OP = 3'd1;
  localparam logic [2:0] ST_WAIT_B  = 3'd2;
  localparam logic [2:0] ST_WAIT_EQ = 3'd3;
  localparam logic [2:0] ST_EXEC    = 3'd4;

  // Keypad codes above the digit range
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_ADD       = 4'hA;
  localparam logic [3:0] KEY_SUB       = 4'hB;
  localparam logic [3:0] KEY_MUL       = 4'hC;
  localparam logic [3:0] KEY_RSVD      = 4'hD;
  localparam logic [3:0] KEY_EQ        = 4'hE;
  localparam logic [3:0] KEY_CLR       = 4'hF;

  // Operator encodings presented on the op output
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10
  } op_e;

  // Coarse key categories used by the controller
  typedef enum logic [2:0] {
    KC_DIGIT = 3'd0,
    KC_OPER  = 3'd1,
    KC_EQ    = 3'd2,
    KC_RSVD  = 3'd3,
    KC_CLR   = 3'd4
  } key_class_e;

  // Map a raw key code onto its category
  function automatic key_class_e classify_key(input logic [3:0] code);
    key_class_e kc;
    if (code <= KEY_DIGIT_MAX) begin
      kc = KC_DIGIT;
    end else begin
      case (code)
        KEY_ADD, KEY_SUB, KEY_MUL: kc = KC_OPER;
        KEY_EQ:                    kc = KC_EQ;
        KEY_CLR:                   kc = KC_CLR;
        KEY_RSVD:                  kc = KC_RSVD;
        default:                   kc = KC_RSVD;
      endcase
    end
    return kc;
  endfunction

  // Translate an operator key into the op encoding
  function automatic logic [1:0] key_to_op(input logic [3:0] code);
    logic [1:0] o;
    case (code)
      KEY_ADD: o = OP_ADD;
      KEY_SUB: o = OP_SUB;
      KEY_MUL: o = OP_MUL;
      default: o = OP_ADD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/operand_timeout_cnt.sv
// Idle-cycle counter for operand entry. Counts cycles without a key while
// enabled and flags expiry on the cycle that would complete TIMEOUT_CYCLES
// idle cycles, so the controller's registered response lands exactly then.
// Only instantiated when OPERAND_TIMEOUT_EN is defined.
module operand_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd27_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

  logic [CNT_W-1:0] cnt_r;

  // Idle counter: cleared by any key or when not waiting, saturates at the last count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= CNT_ZERO;
    end else if (restart || !enable) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r != CNT_LAST) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = enable && !restart && (cnt_r == CNT_LAST);

endmodule

// File: rtl/operand_entry_ctrl.sv
// Operand entry controller: sequences keypad entry A, operator, B, equals,
// then waits for the ALU. All outputs are registered and respond one cycle
// after the sampled key_valid / alu_done.
// Optional feature macro: OPERAND_TIMEOUT_EN (abort entry after idle timeout).
module operand_entry_ctrl
  import operand_entry_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd27_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       alu_done,
  output logic       load_a,
  output logic       load_b,
  output logic [3:0] num,
  output logic       clr,
  output logic [1:0] op,
  output logic       start,
  output logic       busy,
  output logic       error
);

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [3:0] num_nxt_s;
  logic [1:0] op_nxt_s;
  logic       load_a_nxt_s;
  logic       load_b_nxt_s;
  logic       clr_nxt_s;
  logic       start_nxt_s;
  logic       busy_nxt_s;
  logic       error_nxt_s;
  logic       timeout_s;
  key_class_e key_class_s;

  assign key_class_s = classify_key(key_code);

  // A zero-length timeout would make entry impossible; refuse it at elaboration
  if (TIMEOUT_CYCLES == 32'd0) begin : g_bad_timeout
    $error("operand_entry_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef OPERAND_TIMEOUT_EN
  logic waiting_s;

  // Timeout only applies while part-way through entering an expression
  assign waiting_s = (state_r == ST_WAIT_OP) || (state_r == ST_WAIT_B) ||
                     (state_r == ST_WAIT_EQ);

  operand_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .restart (key_valid),
    .enable  (waiting_s),
    .expired (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output decode; clear beats timeout beats normal keys
  always_comb begin
    state_nxt_s  = state_r;
    num_nxt_s    = num;
    op_nxt_s     = op;
    load_a_nxt_s = 1'b0;
    load_b_nxt_s = 1'b0;
    clr_nxt_s    = 1'b0;
    start_nxt_s  = 1'b0;
    error_nxt_s  = 1'b0;

    if (key_valid && (key_class_s == KC_CLR)) begin
      clr_nxt_s   = 1'b1;
      op_nxt_s    = OP_ADD;
      state_nxt_s = ST_WAIT_A;
    end else if (timeout_s) begin
      clr_nxt_s   = 1'b1;
      error_nxt_s = 1'b1;
      op_nxt_s    = OP_ADD;
      state_nxt_s = ST_WAIT_A;
    end else begin
      case (state_r)
        ST_WAIT_A, ST_WAIT_OP: begin
          if (key_valid) begin
            case (key_class_s)
              KC_DIGIT: begin
                num_nxt_s    = key_code;
                load_a_nxt_s = 1'b1;
                state_nxt_s  = ST_WAIT_OP;
              end
              KC_OPER: begin
                if (state_r == ST_WAIT_OP) begin
                  op_nxt_s    = key_to_op(key_code);
                  state_nxt_s = ST_WAIT_B;
                end else begin
                  error_nxt_s = 1'b1;
                end
              end
              default: error_nxt_s = 1'b1;
            endcase
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_WAIT_B, ST_WAIT_EQ: begin
          if (key_valid) begin
            case (key_class_s)
              KC_DIGIT: begin
                num_nxt_s    = key_code;
                load_b_nxt_s = 1'b1;
                state_nxt_s  = ST_WAIT_EQ;
              end
              KC_OPER: begin
                if (state_r == ST_WAIT_EQ) begin
                  op_nxt_s = key_to_op(key_code);
                end else begin
                  error_nxt_s = 1'b1;
                end
              end
              KC_EQ: begin
                if (state_r == ST_WAIT_EQ) begin
                  start_nxt_s = 1'b1;
                  state_nxt_s = ST_EXEC;
                end else begin
                  error_nxt_s = 1'b1;
                end
              end
              default: error_nxt_s = 1'b1;
            endcase
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_EXEC: begin
          // alu_done completes the operation; any concurrent non-clear key is dropped
          if (alu_done) begin
            state_nxt_s = ST_WAIT_A;
          end else begin
            state_nxt_s = ST_EXEC;
          end
          if (key_valid) begin
            error_nxt_s = 1'b1;
          end else begin
            error_nxt_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = ST_WAIT_A;
          op_nxt_s    = OP_ADD;
        end
      endcase
    end

    busy_nxt_s = (state_nxt_s == ST_EXEC);
  end

  // State and output registers; reset abandons any operation without pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_WAIT_A;
      num     <= 4'h0;
      op      <= OP_ADD;
      load_a  <= 1'b0;
      load_b  <= 1'b0;
      clr     <= 1'b0;
      start   <= 1'b0;
      busy    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      num     <= num_nxt_s;
      op      <= op_nxt_s;
      load_a  <= load_a_nxt_s;
      load_b  <= load_b_nxt_s;
      clr     <= clr_nxt_s;
      start   <= start_nxt_s;
      busy    <= busy_nxt_s;
      error   <= error_nxt_s;
    end
  end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Self-checking bench for operand_entry_ctrl: directed scenarios followed by
// randomized key / alu_done traffic, all checked against a behavioural model
// that tracks "what has been entered so far" rather than FSM states.
// Timeout scenarios are exercised when OPERAND_TIMEOUT_EN is defined.
module tb_operand_entry_ctrl;

  localparam int unsigned TB_TIMEOUT = 32'd8;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       alu_done;
  logic       load_a;
  logic       load_b;
  logic [3:0] num;
  logic       clr;
  logic [1:0] op;
  logic       start;
  logic       busy;
  logic       error;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the user has entered so far
  bit       m_have_a, m_have_op, m_have_b, m_running;
  int       m_idle;
  logic [3:0] m_num;
  logic [1:0] m_op;
  bit       e_load_a, e_load_b, e_clr, e_start, e_error;

  operand_entry_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .alu_done  (alu_done),
    .load_a    (load_a),
    .load_b    (load_b),
    .num       (num),
    .clr       (clr),
    .op        (op),
    .start     (start),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have_a = 0; m_have_op = 0; m_have_b = 0; m_running = 0;
    m_idle = 0; m_num = 4'h0; m_op = 2'b00;
    e_load_a = 0; e_load_b = 0; e_clr = 0; e_start = 0; e_error = 0;
  endtask

  task automatic model_clear();
    m_have_a = 0; m_have_op = 0; m_have_b = 0; m_running = 0;
    m_idle = 0; m_op = 2'b00;
  endtask

  // One sampled cycle of the reference behaviour
  task automatic model_step(input bit kv, input logic [3:0] kc, input bit ad);
    bit fire;
    fire = 0;
    e_load_a = 0; e_load_b = 0; e_clr = 0; e_start = 0; e_error = 0;
`ifdef OPERAND_TIMEOUT_EN
    if (kv) m_idle = 0;
    else if (m_have_a && !m_running) begin
      m_idle++;
      if (m_idle == int'(TB_TIMEOUT)) fire = 1;
    end else m_idle = 0;
`endif
    if (kv && kc == 4'hF) begin
      model_clear(); e_clr = 1;
    end else if (fire) begin
      model_clear(); e_clr = 1; e_error = 1;
    end else if (m_running) begin
      if (ad) m_running = 0;
      if (kv) e_error = 1;
    end else if (kv) begin
      if (kc <= 4'h9) begin
        m_num = kc;
        if (!m_have_op) begin e_load_a = 1; m_have_a = 1; end
        else begin e_load_b = 1; m_have_b = 1; end
      end else if (kc >= 4'hA && kc <= 4'hC) begin
        if (m_have_b || (m_have_a && !m_have_op)) begin
          m_op = 2'(kc - 4'hA); m_have_op = 1;
        end else e_error = 1;
      end else if (kc == 4'hE && m_have_b) begin
        e_start = 1; m_running = 1;
        m_have_a = 0; m_have_op = 0; m_have_b = 0;
      end else e_error = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("load_a", 32'(load_a), 32'(e_load_a));
    check_eq("load_b", 32'(load_b), 32'(e_load_b));
    check_eq("num",    32'(num),    32'(m_num));
    check_eq("clr",    32'(clr),    32'(e_clr));
    check_eq("op",     32'(op),     32'(m_op));
    check_eq("start",  32'(start),  32'(e_start));
    check_eq("busy",   32'(busy),   32'(m_running));
    check_eq("error",  32'(error),  32'(e_error));
  endtask

  task automatic cycle(input bit kv, input logic [3:0] kc, input bit ad);
    @(negedge clk);
    key_valid = kv; key_code = kc; alu_done = ad;
    @(posedge clk);
    #1;
    model_step(kv, kc, ad);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 4'h0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle, released on a falling edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_async_zero", {24'h0, load_a, load_b, clr, start, busy, error, op},
             32'h0);
    check_eq("rst_num", 32'(num), 32'h0);
    key_valid = 1'b1; key_code = 4'h3; alu_done = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_hold_zero", {24'h0, load_a, load_b, clr, start, busy, error, op},
             32'h0);
    @(negedge clk);
    key_valid = 1'b0; alu_done = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; alu_done = 1'b0;
    model_reset();
    #2 rst = 1'b0;
    #1;
    check_eq("reset_outputs", {24'h0, load_a, load_b, clr, start, busy, error, op}, 32'h0);
    check_eq("reset_num", 32'(num), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // 3 + 5 =, then ALU completes
    cycle(1, 4'h3, 0); check_eq("s1_load_a", 32'(load_a), 32'd1); check_eq("s1_num", 32'(num), 32'd3);
    cycle(1, 4'hA, 0);
    cycle(1, 4'h5, 0); check_eq("s1_load_b", 32'(load_b), 32'd1); check_eq("s1_num_b", 32'(num), 32'd5);
    cycle(1, 4'hE, 0); check_eq("s1_start", 32'(start), 32'd1); check_eq("s1_busy", 32'(busy), 32'd1);
    idle(3);
    cycle(0, 4'h0, 1); check_eq("s1_done_busy", 32'(busy), 32'd0);
    cycle(1, 4'h1, 0); check_eq("s1_back_wait_a", 32'(load_a), 32'd1);
    cycle(1, 4'hF, 0); check_eq("s1_clr", 32'(clr), 32'd1);

    // 2 then 7 replaces A, then - 4 =
    cycle(1, 4'h2, 0);
    cycle(1, 4'h7, 0); check_eq("s2_replace_a", 32'(num), 32'd7);
    cycle(1, 4'hB, 0); check_eq("s2_op_sub", 32'(op), 32'd1);
    cycle(1, 4'h4, 0);
    cycle(1, 4'hC, 0); check_eq("s2_op_update", 32'(op), 32'd2);
    cycle(1, 4'hB, 0);
    cycle(1, 4'hE, 0); check_eq("s2_start", 32'(start), 32'd1);
    cycle(1, 4'hE, 0); check_eq("s2_start_once", 32'(start), 32'd0);
    check_eq("s2_exec_key_err", 32'(error), 32'd1);
    cycle(1, 4'h6, 1); check_eq("s2_key_with_done_err", 32'(error), 32'd1);
    check_eq("s2_key_with_done_busy", 32'(busy), 32'd0);

    // Rejected keys: = in WAIT_A, reserved in WAIT_B
    cycle(1, 4'hE, 0); check_eq("s3_eq_err", 32'(error), 32'd1);
    cycle(1, 4'h8, 0);
    cycle(1, 4'hA, 0);
    cycle(1, 4'hD, 0); check_eq("s3_rsvd_err", 32'(error), 32'd1);
    check_eq("s3_no_load", 32'(load_b), 32'd0);
    cycle(1, 4'h9, 0); check_eq("s3_still_wait_b", 32'(load_b), 32'd1);

    // Clear and alu_done together in EXEC; later alu_done ignored
    cycle(1, 4'hE, 0);
    cycle(1, 4'hF, 1); check_eq("s4_clr", 32'(clr), 32'd1);
    check_eq("s4_busy", 32'(busy), 32'd0); check_eq("s4_no_err", 32'(error), 32'd0);
    cycle(0, 4'h0, 1);

    // Reset in the middle of WAIT_EQ
    cycle(1, 4'h1, 0); cycle(1, 4'hA, 0); cycle(1, 4'h2, 0);
    do_reset();
    cycle(1, 4'h4, 0); check_eq("s5_after_rst_load_a", 32'(load_a), 32'd1);

`ifdef OPERAND_TIMEOUT_EN
    // Idle timeout, and a key at idle cycle 7 restarting the count
    cycle(1, 4'hF, 0);
    cycle(1, 4'h6, 0);
    idle(7); check_eq("to_not_yet", 32'(clr), 32'd0);
    cycle(1, 4'h5, 0);
    idle(7); check_eq("to_restarted", 32'(clr), 32'd0);
    idle(1); check_eq("to_clr", 32'(clr), 32'd1); check_eq("to_err", 32'(error), 32'd1);
    cycle(1, 4'h2, 0); check_eq("to_wait_a", 32'(load_a), 32'd1);
    idle(20);
`endif

    // Randomized traffic with alternating dense and sparse key phases
    for (int i = 0; i < 4000; i++) begin
      bit kv, ad;
      logic [3:0] kc;
      if (((i / 250) % 2) == 1) kv = ($urandom_range(0, 19) == 0);
      else kv = ($urandom_range(0, 9) < 7);
      kc = 4'($urandom_range(0, 15));
      ad = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle(kv, kc, ad);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
